musa_stage_sequencer: RTL
=========================

Name: musa_stage_sequencer

Overview:
Multi-cycle stage sequencer for the MUSA core. It drives the IFH/ID/EX/MEM/WB stage enables and the PC write strobe, and tells the opcode decoder which stage is active. It skips stages an instruction does not need, stalls on memory handshakes, handles HALT/resume, and flags memory timeouts. It sits between the opcode decoder and the datapath; the decoder's control outputs are qualified by this block's stage enables.

Parameters:
MEM_TIMEOUT, 15, maximum wait cycles for mem_ready in IFH or MEM before faulting; legal range 1..255.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
opcode  in  6  instruction opcode; valid from ID onward
mem_ready  in  1  instruction/data memory access complete this cycle
resume  in  1  leave HALT state
stage  out  3  current stage: 000 IFH, 001 ID, 010 EX, 011 MEM, 100 WB, 111 HALT
fetch_en  out  1  high while stage==IFH
decode_en  out  1  high while stage==ID
exec_en  out  1  high while stage==EX
mem_en  out  1  high while stage==MEM
wb_en  out  1  high while stage==WB
write_pc  out  1  one-cycle PC update strobe
halted  out  1  high while stage==HALT
mem_err  out  1  sticky timeout flag
instr_count  out  CNT_W  retired-instruction counter

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- On reset: stage=IFH, opcode_q=000000, wait counter=0, mem_err=0, instr_count=0, write_pc=0.
- Stage enables and halted are one-hot decodes of the state register; they never glitch between states.
- opcode_q is captured from opcode on the last cycle of ID. Later decisions use only opcode_q.
- Instruction classes by opcode_q:
  - ALU: 000000, 001000, 001100, 001101, 001110.
  - LOAD: 100011.
  - STORE: 101011.
  - HALT: 000010.
  - CTRL: everything else, including jr, jpc, call, ret, brfl, nop, and unknown opcodes.
- Transitions:
  - IFH -> ID when mem_ready=1; otherwise stay in IFH and increment the wait counter.
  - ID -> EX after 1 cycle.
  - EX -> WB for ALU; EX -> MEM for LOAD or STORE; EX -> IFH for CTRL; EX -> HALT for HALT.
  - MEM: wait for mem_ready. LOAD -> WB; STORE -> IFH.
  - WB -> IFH after 1 cycle.
  - HALT -> IFH on resume=1.
- write_pc is combinational and is high exactly on the cycle the FSM leaves for IFH from EX, MEM or WB.
  - It is also high on the HALT -> IFH transition, which advances past the halt.
  - It is never high while stalled.
  - It is not asserted on entry to HALT.
- instr_count increments, wrapping modulo 2^CNT_W, on every write_pc cycle except the resume transition. HALT is counted on entry to HALT.
- Latency with mem_ready held 1: ALU 4 cycles, LOAD 5, STORE 4, CTRL 3. Each stall cycle adds 1.
- Wait counter: cleared on entering IFH or MEM and whenever mem_ready=1.
  - If it reaches MEM_TIMEOUT while still waiting, the next state is HALT and mem_err is set.
  - mem_err is cleared only by reset.
  - resume from a timeout HALT goes to IFH with write_pc=0, so the faulted instruction is refetched.
- mem_ready sampled outside IFH or MEM is ignored.
- resume sampled outside HALT is ignored.
- Reset asserted in any state, including mid-stall, wins over every transition. No write_pc is issued that cycle.

Decomposition:
- Shared package musa_ctrl_pkg: opcode constants (r_type, addi, andi, ori, subi, lw, sw, halt, call, ret, jr, jpc, brfl, nop) and the stage encoding constants above. The opcode decoder uses the same package.
- One natural sub-module: musa_mem_wait_timer, which holds the wait counter with clear/enable and a timeout output.

Test Plan:
- Reset then r_type (000000), mem_ready=1 -> stage sequence 000, 001, 010, 100, 000; write_pc high only in the WB cycle (cycle 4); instr_count=1.
- lw (100011) with mem_ready low for 2 cycles in MEM -> 000, 001, 010, 011, 011, 011, 100; write_pc only in WB; 7 cycles total.
- jpc (001001) then sw (101011) -> jpc takes 3 cycles with write_pc in EX; sw takes 4 cycles with write_pc in MEM; instr_count=2.
- halt (000010) -> stage 111 and halted=1 after EX, no write_pc; hold 5 cycles, then resume=1 -> write_pc=1 and stage=000 next; instr_count unchanged by the resume.
- MEM_TIMEOUT=3, mem_ready held 0 in IFH -> HALT after 3 wait cycles, mem_err=1; resume -> IFH with write_pc=0; mem_err stays 1 until reset.
- reset pulsed during a MEM stall -> next cycle stage=000, instr_count=0, mem_err=0, write_pc=0.

Source files
------------

// File: rtl/musa_ctrl_pkg.sv
// musa_ctrl_pkg
//   Shared control definitions for the MUSA core: opcode constants, the
//   stage encoding driven on musa_stage_sequencer.stage, instruction
//   classes and the opcode -> class mapping. The opcode decoder imports
//   the same package so both blocks agree on encodings.
package musa_ctrl_pkg;

  // Opcodes
  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_SUBI   = 6'b001110;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_HALT   = 6'b000010;
  localparam logic [5:0] OP_CALL   = 6'b000011;
  localparam logic [5:0] OP_RET    = 6'b000111;
  localparam logic [5:0] OP_JR     = 6'b000100;
  localparam logic [5:0] OP_JPC    = 6'b001001;
  localparam logic [5:0] OP_BRFL   = 6'b000101;
  localparam logic [5:0] OP_NOP    = 6'b111111;

  // Width of the memory wait counter; large enough for a timeout of 255.
  localparam int TIMER_W = 8;

  // Stage encoding as seen on the stage output.
  typedef enum logic [2:0] {
    STG_IFH  = 3'b000,
    STG_ID   = 3'b001,
    STG_EX   = 3'b010,
    STG_MEM  = 3'b011,
    STG_WB   = 3'b100,
    STG_HALT = 3'b111
  } stage_e;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_HALT,
    CLS_CTRL
  } iclass_e;

  // Anything not explicitly ALU/LOAD/STORE/HALT is a control-flow (or
  // unknown) instruction that finishes in EX.
  function automatic iclass_e classify(input logic [5:0] op);
    iclass_e cls;
    case (op)
      OP_R_TYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SUBI: cls = CLS_ALU;
      OP_LW:                                        cls = CLS_LOAD;
      OP_SW:                                        cls = CLS_STORE;
      OP_HALT:                                      cls = CLS_HALT;
      default:                                      cls = CLS_CTRL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/musa_mem_wait_timer.sv
// musa_mem_wait_timer
//   Counts consecutive cycles spent waiting on mem_ready and flags the
//   cycle on which the count reaches MEM_TIMEOUT.
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   i_clear   in   zero the counter (has priority over i_enable)
//   i_enable  in   this cycle is a wait cycle; count it
//   o_timeout out  this wait cycle is the MEM_TIMEOUT-th in a row
module musa_mem_wait_timer
  import musa_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_timeout
);

  localparam logic [TIMER_W-1:0] LAST_WAIT = TIMER_W'(MEM_TIMEOUT - 1);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  // Counting this cycle makes the count reach MEM_TIMEOUT.
  assign o_timeout = i_enable && (r_count == LAST_WAIT);

endmodule

// File: rtl/musa_stage_sequencer.sv
// musa_stage_sequencer
//   Multi-cycle stage sequencer for the MUSA core. Steps IFH/ID/EX/MEM/WB,
//   skipping stages an instruction class does not need, stalls on
//   mem_ready, parks in HALT until resume, and faults into HALT (sticky
//   mem_err) when a memory wait exceeds MEM_TIMEOUT cycles.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   opcode[5:0]       instruction opcode, captured at the end of ID
//   mem_ready         memory access complete (used in IFH and MEM only)
//   resume            leave HALT (used in HALT only)
//   stage[2:0]        current stage encoding
//   fetch_en..wb_en   one-hot stage enables
//   halted            stage is HALT
//   write_pc          PC update strobe, combinational
//   mem_err           sticky memory timeout flag
//   instr_count       retired instruction counter (wraps)
module musa_stage_sequencer
  import musa_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  input  logic             resume,
  output logic [2:0]       stage,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             write_pc,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_count
);

  stage_e           r_state;
  stage_e           w_next_state;
  logic [5:0]       r_opcode_q;
  logic             r_mem_err;
  logic             r_fault_halt;   // current HALT was entered by a timeout
  logic [CNT_W-1:0] r_instr_count;

  iclass_e w_class;
  logic    w_pc_step;     // leaving EX/MEM/WB for IFH: instruction retires
  logic    w_resume_pc;   // resume from an instruction HALT
  logic    w_halt_entry;  // HALT instruction retires on entry to HALT
  logic    w_fault;       // memory wait timed out this cycle
  logic    w_in_wait;
  logic    w_enter_wait;
  logic    w_timer_en;
  logic    w_timer_clear;
  logic    w_timeout;

  assign w_class = classify(r_opcode_q);

  assign w_in_wait     = (r_state == STG_IFH) || (r_state == STG_MEM);
  assign w_enter_wait  = (w_next_state != r_state) &&
                         ((w_next_state == STG_IFH) || (w_next_state == STG_MEM));
  assign w_timer_en    = w_in_wait && !mem_ready;
  assign w_timer_clear = mem_ready || w_enter_wait;

  musa_mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_en),
    .o_timeout (w_timeout)
  );

  always_comb begin
    w_next_state = r_state;
    w_pc_step    = 1'b0;
    w_resume_pc  = 1'b0;
    w_halt_entry = 1'b0;
    w_fault      = 1'b0;
    case (r_state)
      STG_IFH: begin
        if (mem_ready) begin
          w_next_state = STG_ID;
        end else if (w_timeout) begin
          w_next_state = STG_HALT;
          w_fault      = 1'b1;
        end
      end
      STG_ID: w_next_state = STG_EX;
      STG_EX: begin
        case (w_class)
          CLS_ALU:              w_next_state = STG_WB;
          CLS_LOAD, CLS_STORE:  w_next_state = STG_MEM;
          CLS_HALT: begin
            w_next_state = STG_HALT;
            w_halt_entry = 1'b1;
          end
          default: begin
            w_next_state = STG_IFH;
            w_pc_step    = 1'b1;
          end
        endcase
      end
      STG_MEM: begin
        if (mem_ready) begin
          if (w_class == CLS_LOAD) begin
            w_next_state = STG_WB;
          end else begin
            w_next_state = STG_IFH;
            w_pc_step    = 1'b1;
          end
        end else if (w_timeout) begin
          w_next_state = STG_HALT;
          w_fault      = 1'b1;
        end
      end
      STG_WB: begin
        w_next_state = STG_IFH;
        w_pc_step    = 1'b1;
      end
      STG_HALT: begin
        if (resume) begin
          w_next_state = STG_IFH;
          // After a timeout the faulted instruction is refetched, so the
          // PC must not advance.
          w_resume_pc  = !r_fault_halt;
        end
      end
      default: w_next_state = STG_IFH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= STG_IFH;
      r_opcode_q    <= '0;
      r_mem_err     <= 1'b0;
      r_fault_halt  <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == STG_ID) begin
        r_opcode_q <= opcode;
      end
      if (w_fault) begin
        r_mem_err    <= 1'b1;
        r_fault_halt <= 1'b1;
      end else if (w_halt_entry) begin
        r_fault_halt <= 1'b0;
      end
      if (w_pc_step || w_halt_entry) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

  assign stage       = r_state;
  assign fetch_en    = (r_state == STG_IFH);
  assign decode_en   = (r_state == STG_ID);
  assign exec_en     = (r_state == STG_EX);
  assign mem_en      = (r_state == STG_MEM);
  assign wb_en       = (r_state == STG_WB);
  assign halted      = (r_state == STG_HALT);
  // Reset overrides any transition, so no strobe in a reset cycle.
  assign write_pc    = !reset && (w_pc_step || w_resume_pc);
  assign mem_err     = r_mem_err;
  assign instr_count = r_instr_count;

endmodule
